// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port integer register file with a per-register busy
// scoreboard for the pipelined NPC core.
//
// Decode reads up to READ_PORTS operands per cycle. Each operand comes with a
// busy flag. Issue marks a destination register pending. Writeback commits
// data and clears the pending mark. Flush clears every pending mark. Register
// 0 is hardwired to zero and is never busy.
//
// Optional build macro: REGFILE_BYPASS_EN
//   When defined, a writeback in the current cycle is forwarded to every read
//   port whose address matches. Matching ports see wdata and a clear busy flag.
//   When undefined, reads return the stored value and the pre-edge busy bit.
//
// Ports:
//   clk        clock; all state updates on posedge
//   rst        synchronous active-high reset (priority over wen/iss/flush)
//   raddr      packed read addresses, port k at [k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
//   rdata      packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rbusy      busy flag per read port
//   iss_valid  issue request: mark iss_rd pending
//   iss_rd     destination register of the issuing instruction
//   iss_stall  issue blocked because iss_rd is still pending
//   wen        writeback enable
//   waddr      writeback register
//   wdata      writeback data
//   flush      clear all pending bits
//   busy_vec   current scoreboard, for debug and difftest
module regfile_sb #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_NUM        = 32,
  parameter int READ_PORTS     = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [READ_PORTS*REG_ADDR_WIDTH-1:0] raddr,
  output logic [READ_PORTS*DATA_WIDTH-1:0]     rdata,
  output logic [READ_PORTS-1:0]                rbusy,
  input  logic                                 iss_valid,
  input  logic [REG_ADDR_WIDTH-1:0]            iss_rd,
  output logic                                 iss_stall,
  input  logic                                 wen,
  input  logic [REG_ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]                wdata,
  input  logic                                 flush,
  output logic [REG_NUM-1:0]                   busy_vec
);

  localparam logic [31:0] REG_NUM_U = 32'(REG_NUM);

  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
  logic [DATA_WIDTH-1:0] regs_d [REG_NUM];
  logic [REG_NUM-1:0]    busy_q;
  logic [REG_NUM-1:0]    busy_d;

  // A register address is usable only if it is nonzero and backed by storage.
  // Reads of x0 and of unbacked indices return zero. Writes to them are dropped.
  function automatic logic addrOk(input logic [REG_ADDR_WIDTH-1:0] a);
    return (a != '0) && (32'(a) < REG_NUM_U);
  endfunction

  // Issue is held off while its destination is pending. A writeback to that
  // same register in this cycle retires the older writer, so the issue may
  // proceed. The register then stays busy for the new writer.
  always_comb begin
    iss_stall = 1'b0;
    if (iss_valid && addrOk(iss_rd)) begin
      iss_stall = busy_q[iss_rd] && !(wen && (waddr == iss_rd));
    end
  end

  // Combinational read ports. With bypass enabled, a matching writeback
  // in the same cycle overrides the stored value. That register is then
  // reported not busy, because its producer is completing now.
  always_comb begin
    logic [REG_ADDR_WIDTH-1:0] a;
    a     = '0;
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      a = raddr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      if (addrOk(a)) begin
        rdata[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[a];
        rbusy[k]                          = busy_q[a];
`ifdef REGFILE_BYPASS_EN
        if (wen && (waddr == a)) begin
          rdata[k*DATA_WIDTH +: DATA_WIDTH] = wdata;
          rbusy[k]                          = 1'b0;
        end
`endif
      end
    end
  end

  // Next-state for data and scoreboard. When an issue and a writeback target
  // the same register in the same cycle, the issue wins. The newer writer
  // therefore stays pending. Flush drops every pending mark and any concurrent
  // issue. A concurrent writeback still commits its data.
  always_comb begin
    logic setBit;
    logic clrBit;
    setBit = 1'b0;
    clrBit = 1'b0;
    regs_d = regs_q;
    busy_d = busy_q;
    if (wen && addrOk(waddr)) begin
      regs_d[waddr] = wdata;
    end
    for (int i = 1; i < REG_NUM; i++) begin
      setBit    = iss_valid && !iss_stall && !flush && (32'(iss_rd) == 32'(i));
      clrBit    = wen && (32'(waddr) == 32'(i));
      busy_d[i] = setBit || (busy_q[i] && !clrBit && !flush);
    end
    busy_d[0] = 1'b0;
  end

  // State registers. Reset zeroes data and scoreboard. Reset has priority
  // over every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scoreboard bench for regfile_sb (default parameters).
// The stimulus process drives inputs just after each rising edge. It then
// queues the outputs expected for that cycle. The monitor process samples at
// the falling edge and compares against everything queued for that cycle.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_stall;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        flush;
  logic [31:0] busy_vec;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } ExpT;

  ExpT expQ[$];
  int  checks = 0;
  int  errors = 0;

  regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_stall (iss_stall),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .flush     (flush),
    .busy_vec  (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every non-reset input for the coming cycle.
  task automatic applyStimulus(input logic iv, input logic [4:0] rd,
                               input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic fl,
                               input logic [4:0] r0, input logic [4:0] r1);
    iss_valid = iv;
    iss_rd    = rd;
    wen       = we;
    waddr     = wa;
    wdata     = wd;
    flush     = fl;
    raddr     = {r1, r0};
  endtask

  // Queue an expected output value for this cycle.
  // sel: 0 rdata port0, 1 rdata port1, 2 rbusy, 3 iss_stall, 4 busy_vec
  task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
    ExpT e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: at each falling edge, retire every expectation queued this cycle.
  initial begin
    ExpT         e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        case (e.sel)
          0:       act = rdata[31:0];
          1:       act = rdata[63:32];
          2:       act = 32'(rbusy);
          3:       act = 32'(iss_stall);
          default: act = busy_vec;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    tick();
    tick();
    rst = 1'b0;

    // Every register reads zero and not busy after reset.
    for (int a = 0; a < 32; a += 2) begin
      applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'(a), 5'(a + 1));
      checkOutput("rst_rd0", 0, 32'h0);
      checkOutput("rst_rd1", 1, 32'h0);
      checkOutput("rst_rbusy", 2, 32'h0);
      checkOutput("rst_busyvec", 4, 32'h0);
      tick();
    end

    // Writes to x0 are dropped.
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    checkOutput("x0_zero", 0, 32'h0);
    checkOutput("x0_busyvec", 4, 32'h0);
    tick();

    // Issue to x5, re-issue stalls, then writeback clears it.
    applyStimulus(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
    checkOutput("iss5_nostall", 3, 32'h0);
    checkOutput("iss5_prebusy", 2, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
    checkOutput("x5_rbusy", 2, 32'h1);
    checkOutput("x5_busyvec", 4, 32'h20);
    tick();
    applyStimulus(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
    checkOutput("reiss5_stall", 3, 32'h1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd5, 5'd0);
    checkOutput("wb5_rdata", 0, BYP ? 32'h1234 : 32'h0);
    checkOutput("wb5_rbusy", 2, BYP ? 32'h0 : 32'h1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
    checkOutput("x5_data", 0, 32'h1234);
    checkOutput("x5_free", 2, 32'h0);
    checkOutput("x5_bvclear", 4, 32'h0);
    tick();

    // Same-cycle issue and writeback to busy x7: no stall, stays busy.
    applyStimulus(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd7, 1'b1, 5'd7, 32'h77, 1'b0, 5'd7, 5'd0);
    checkOutput("x7_nostall", 3, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
    checkOutput("x7_data", 0, 32'h77);
    checkOutput("x7_busyvec", 4, 32'h80);
    checkOutput("x7_rbusy", 2, 32'h1);
    tick();

    // Make x3, x9 and x12 busy, then flush together with an issue to x4.
    applyStimulus(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd12, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0);
    checkOutput("flush_prebv", 4, 32'h1288);
    checkOutput("flush_stall", 3, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd7);
    checkOutput("flush_bv", 4, 32'h0);
    checkOutput("flush_x4", 2, 32'h0);
    checkOutput("flush_x7data", 1, 32'h77);
    tick();

    // Write a non-busy x10 while port 1 reads it.
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd10, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd10);
    checkOutput("wr10_same", 1, BYP ? 32'hA5A5A5A5 : 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10);
    checkOutput("wr10_next", 1, 32'hA5A5A5A5);
    checkOutput("wr10_bv", 4, 32'h0);
    tick();

    // Issue to x0 never stalls and never marks anything.
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    checkOutput("iss0_stall", 3, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    checkOutput("iss0_bv", 4, 32'h0);
    tick();

    // x2 = 0x55 and busy, then reset while writing x2.
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd2, 32'h55, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd2, 32'h99, 1'b0, 5'd2, 5'd10);
    checkOutput("rstpre_bv", 4, 32'h4);
    checkOutput("rstpre_x2", 0, BYP ? 32'h99 : 32'h55);
    checkOutput("rstpre_x10", 1, 32'hA5A5A5A5);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd2, 5'd10);
    checkOutput("rst_x2", 0, 32'h0);
    checkOutput("rst_x10", 1, 32'h0);
    checkOutput("rst_bv", 4, 32'h0);
    checkOutput("rst_rbusy2", 2, 32'h0);
    tick();
    tick();

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: got %0d pending expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-read-port integer register file with a per-register busy scoreboard for the pipelined NPC core. Decode reads up to READ_PORTS operands per cycle and gets a busy flag per operand. Issue marks a destination register pending. Writeback commits data and clears the pending mark. A flush clears all pending marks on pipeline redirect. Register 0 is hardwired to zero and is never busy.

Parameters:
- REG_ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, register data width
- REG_NUM, 32, number of registers; must be ≤ 2**REG_ADDR_WIDTH
- READ_PORTS, 2, number of read ports; 1..4

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- raddr  in  READ_PORTS*REG_ADDR_WIDTH  packed read addresses; port k at bits [k*W +: W]
- rdata  out  READ_PORTS*DATA_WIDTH  packed read data, same packing
- rbusy  out  READ_PORTS  busy flag for each read address
- iss_valid  in  1  issue request: mark iss_rd pending
- iss_rd  in  REG_ADDR_WIDTH  destination register of the issuing instruction
- iss_stall  out  1  issue blocked: iss_rd is already pending
- wen  in  1  writeback enable
- waddr  in  REG_ADDR_WIDTH  writeback register
- wdata  in  DATA_WIDTH  writeback data
- flush  in  1  clear all pending bits
- busy_vec  out  REG_NUM  current scoreboard, for debug and difftest

Behaviour:
- Reset (rst=1 at posedge): all registers 0, all busy bits 0. Reset has priority over wen, iss_valid and flush. During reset, outputs reflect the prior state combinationally; from the cycle after reset, rdata=0, rbusy=0, busy_vec=0.
- Reads are combinational with zero latency.
  - rdata[k] = 0 if raddr[k]==0 or raddr[k]>=REG_NUM; otherwise the stored value.
  - rbusy[k] = busy[raddr[k]], forced 0 for address 0 or an out-of-range address.
- Write: on posedge with wen=1, waddr!=0 and waddr<REG_NUM, reg[waddr] <= wdata. Otherwise there is no state change. Address 0 and out-of-range writes are silently dropped.
- Scoreboard, next-state per register i≠0:
  - set = iss_valid & ~iss_stall & (iss_rd==i) & ~flush
  - clr = wen & (waddr==i)
  - busy'[i] = set | (busy[i] & ~clr & ~flush)
  - Set has priority over clear when both target the same register in the same cycle, so the newer writer stays pending.
- iss_stall = iss_valid & busy[iss_rd] & ~(wen & waddr==iss_rd). This is combinational. A same-cycle writeback to iss_rd releases the stall, and the register stays busy.
- iss_rd==0: never stalls and never sets a bit.
- A write to a non-busy register is legal: data is committed and the bit stays 0.
- flush clears all bits. A write in the same cycle still commits data, and a concurrent issue is dropped.
- Write-then-read in the same cycle: without bypass, the read returns the old value; the new value is visible the next cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when wen=1 and waddr==raddr[k]!=0 (in range), rdata[k]=wdata and rbusy[k]=0 in that same cycle. The same combinational write-to-read forwarding applies on every port.
- Undefined: there is no forwarding. The read returns the stored value, and rbusy reflects the pre-edge busy bit.

Test Plan:
- Reset then read all regs on both ports → rdata=0, rbusy=0, busy_vec=0. Write x0=0xDEADBEEF → x0 still reads 0.
- iss_valid, iss_rd=5 → next cycle busy_vec[5]=1, rbusy=1 for raddr=5. Re-issue rd=5 → iss_stall=1. Then wen, waddr=5, wdata=0x1234 → next cycle reads 0x1234, busy 0.
- Same cycle: iss rd=7 and wen waddr=7 while x7 is busy → iss_stall=0, x7 gets the new data, busy_vec[7] stays 1.
- Set x3, x9, x12 busy; pulse flush together with iss rd=4 → next cycle busy_vec=0, x4 not busy.
- wen waddr=10 wdata=0xA5A5A5A5 with raddr[1]=10 in the same cycle → 0xA5A5A5A5 that cycle with REGFILE_BYPASS_EN, the old value without it; both configurations read 0xA5A5A5A5 the next cycle.
- Assert rst mid-operation with x2 busy and x2=0x55 while wen to x2 → next cycle x2=0, busy_vec=0.
